pll_phase_ctrl: RTL and testbench
=================================

Name: pll_phase_ctrl

Overview:
- Single-clock controller for the ECP5 EHXPLLL dynamic phase port and lock supervision.
- Takes phase-shift requests over a valid/ready handshake. Emits correctly timed PHASESEL/PHASEDIR/PHASESTEP sequences for up to 4 PLL outputs.
- Synchronises and filters the asynchronous PLL LOCK and sequences a downstream reset.
- Sits between the video/DVI clock PLL instance and the core reset/control logic; clocked by the PLL reference clock.

Parameters:
N_CH, 4, number of steerable PLL outputs (1..4)
STEP_W, 8, width of signed step-count request
SETUP_CYC, 2, cycles PHASESEL/PHASEDIR are held stable before first pulse (>=1)
STEP_PULSE, 4, cycles PHASESTEP held low per step (>=1)
STEP_GAP, 4, cycles PHASESTEP held high after each pulse (>=1)
LOCK_FILT, 1024, consecutive synchronised-high LOCK cycles before locked_ok
RST_HOLD, 16, cycles rst_out stays asserted after locked_ok rises
POS_W, 8, width of per-channel phase position counters

Ports:
clk  in  1  reference clock (PLL CLKI domain)
reset  in  1  asynchronous, active-high reset
pll_locked  in  1  raw EHXPLLL LOCK (asynchronous)
req_valid  in  1  phase request valid
req_ready  out  1  request accepted when valid&ready
req_ch  in  2  target output (0=CLKOP,1=CLKOS,2=CLKOS2,3=CLKOS3)
req_steps  in  STEP_W  signed two's-complement step count; negative = lag
phasesel  out  2  to EHXPLLL PHASESEL[1:0]
phasedir  out  1  to EHXPLLL PHASEDIR (1 = negative steps)
phasestep  out  1  to EHXPLLL PHASESTEP, idle high
busy  out  1  FSM not IDLE
done  out  1  one-cycle completion pulse
done_err  out  1  qualifies done: request aborted or invalid
locked_ok  out  1  filtered lock
rst_out  out  1  active-high downstream reset
lock_loss_cnt  out  8  saturating count of locked_ok falling edges
phase_pos  out  N_CH*POS_W  per-channel accumulated phase, ch0 in LSBs

Behaviour:
- Reset values: req_ready=0, phasesel=0, phasedir=0, phasestep=1, busy=0, done=0, done_err=0, locked_ok=0, rst_out=1, lock_loss_cnt=0, phase_pos=0.
- Lock path:
  - pll_locked passes through a 2-FF synchroniser.
  - Counter counts consecutive high synchronised cycles; locked_ok rises when the count reaches LOCK_FILT.
  - Any low synchronised cycle clears the counter and drops locked_ok the next cycle.
- rst_out deasserts RST_HOLD cycles after locked_ok rises. It reasserts in the same cycle locked_ok falls.
- lock_loss_cnt increments on each locked_ok 1->0 transition and saturates at 255.
- req_ready = (state==IDLE) && locked_ok.
- FSM states: IDLE, SETUP, STEP_LO, STEP_GAP, DONE.
- Accept (cycle t0): latch ch, magnitude |req_steps| (STEP_W bits unsigned, so -2^(STEP_W-1) is legal) and sign.
  - steps==0 or req_ch>=N_CH -> DONE. done at t0+1; done_err=1 only for bad channel.
  - Otherwise -> SETUP: phasesel=ch and phasedir=sign are driven from t0+1 and held until IDLE.
- SETUP: SETUP_CYC cycles -> STEP_LO.
- STEP_LO: phasestep=0 for STEP_PULSE cycles. On its last cycle, remaining decrements and phase_pos[ch] moves ±1 (wraps mod 2^POS_W) -> STEP_GAP.
- STEP_GAP: phasestep=1 for STEP_GAP cycles. Then -> STEP_LO if remaining>0, else DONE.
- Done timing for n>0 steps: done asserts at t0 + SETUP_CYC + n*(STEP_PULSE+STEP_GAP) + 1.
- DONE: one cycle with done=1 -> IDLE.
- locked_ok falls mid-operation:
  - in SETUP or STEP_GAP -> DONE with done_err=1;
  - in STEP_LO -> finish the current pulse, then DONE with done_err=1.
- A pulse is never truncated.
- reset mid-operation: all outputs return to reset values immediately (phasestep=1 asynchronously).

Optional Feature:
- PLL_PHASE_TRACK_EN.
- Defined: phase_pos counters implemented as above.
- Undefined: counters removed, phase_pos driven constant 0; all other behaviour identical.

Decomposition:
- Package pll_ctrl_pkg: FSM state enum, CH_W=2 constant, PHASESTEP idle level constant, clog2-derived counter widths.
- Sub-module pll_lock_filter: synchroniser, LOCK_FILT filter, RST_HOLD sequencer, lock_loss_cnt. Instantiated once.

Test Plan:
- LOCK_FILT=16: raise pll_locked -> locked_ok at 2+16 cycles. rst_out falls 16 cycles later. A 1-cycle LOCK glitch low drops locked_ok and re-runs the filter.
- Defaults, req_steps=3, ch=1 -> phasesel=1, phasedir=0, three 4-cycle low pulses 4 cycles apart. done at t0+27, done_err=0, phase_pos[1]=3.
- req_steps=-2 (0xFE), ch=0 from pos 1 -> phasedir=1, two pulses. phase_pos[0]=255 (wrap).
- req_steps=0 -> no phasestep activity, done at t0+1, done_err=0. With N_CH=2, req_ch=3 -> done with done_err=1, no pulses.
- Drop pll_locked during the 2nd pulse of a 5-step request -> pulse completes, done_err=1. lock_loss_cnt=1, req_ready stays 0 until relock.
- Assert reset during STEP_LO -> phasestep=1 immediately, busy=0, rst_out=1, counters cleared.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pll_ctrl_pkg
// Shared types and constants for the EHXPLLL phase/lock controller.
//   state_t        : phase-step sequencer states
//   CH_W           : width of PHASESEL / channel select
//   PHASESTEP_IDLE : resting level of PHASESTEP
//   LOSS_W         : width of the lock-loss counter
//   cnt_width()    : bits needed to hold 0..max_val
//   max3()         : largest of three cycle counts (shared timer sizing)
// ----------------------------------------------------------------------------
package pll_ctrl_pkg;

    localparam int unsigned CH_W           = 2;
    localparam logic        PHASESTEP_IDLE = 1'b1;
    localparam int unsigned LOSS_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_STEP_LO  = 3'd2,
        ST_STEP_GAP = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// ----------------------------------------------------------------------------
// pll_lock_filter
// Synchronises the raw PLL LOCK, requires LOCK_FILT consecutive high samples
// before declaring lock, holds the downstream reset for RST_HOLD cycles after
// lock, and counts lock losses (saturating).
// Ports:
//   clk, reset        : clock, async active-high reset
//   i_pll_locked      : raw asynchronous LOCK
//   o_locked_ok       : filtered lock (registered)
//   o_lock_next_c     : value o_locked_ok takes at the next edge
//   o_rst_out         : active-high downstream reset (registered)
//   o_lock_loss_cnt   : saturating count of o_locked_ok falling edges
// ----------------------------------------------------------------------------
module pll_lock_filter
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_FILT = 1024,
    parameter int unsigned RST_HOLD  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pll_locked,
    output logic              o_locked_ok,
    output logic              o_lock_next_c,
    output logic              o_rst_out,
    output logic [LOSS_W-1:0] o_lock_loss_cnt
);

    localparam int unsigned FILT_W = cnt_width(LOCK_FILT);
    localparam int unsigned HOLD_W = cnt_width(RST_HOLD);

    logic [1:0]        r_sync;
    logic [FILT_W-1:0] r_filt_cnt;
    logic              r_locked_ok;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_rst_out;
    logic [LOSS_W-1:0] r_loss_cnt;

    logic [FILT_W-1:0] w_filt_cnt_next;
    logic              w_lock_next;
    logic [HOLD_W-1:0] w_hold_next;
    logic              w_rst_next;
    logic [LOSS_W-1:0] w_loss_next;

    // Filter, hold sequencer and loss counter next values
    always_comb begin
        w_filt_cnt_next = '0;
        w_hold_next     = '0;
        w_loss_next     = r_loss_cnt;

        // Counter saturates at LOCK_FILT so a long lock keeps locked_ok high
        if (r_sync[1]) begin
            if (r_filt_cnt == FILT_W'(LOCK_FILT)) begin
                w_filt_cnt_next = r_filt_cnt;
            end else begin
                w_filt_cnt_next = r_filt_cnt + FILT_W'(1);
            end
        end
        w_lock_next = r_sync[1] && (w_filt_cnt_next == FILT_W'(LOCK_FILT));

        // Hold counting starts the cycle after locked_ok rises
        if (w_lock_next) begin
            if (r_locked_ok && (r_hold_cnt != HOLD_W'(RST_HOLD))) begin
                w_hold_next = r_hold_cnt + HOLD_W'(1);
            end else begin
                w_hold_next = r_hold_cnt;
            end
        end
        // Reset reasserts on the same edge that drops locked_ok
        w_rst_next = !(w_lock_next && (w_hold_next == HOLD_W'(RST_HOLD)));

        if (r_locked_ok && !w_lock_next && (r_loss_cnt != {LOSS_W{1'b1}})) begin
            w_loss_next = r_loss_cnt + LOSS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync      <= '0;
            r_filt_cnt  <= '0;
            r_locked_ok <= 1'b0;
            r_hold_cnt  <= '0;
            r_rst_out   <= 1'b1;
            r_loss_cnt  <= '0;
        end else begin
            r_sync      <= {r_sync[0], i_pll_locked};
            r_filt_cnt  <= w_filt_cnt_next;
            r_locked_ok <= w_lock_next;
            r_hold_cnt  <= w_hold_next;
            r_rst_out   <= w_rst_next;
            r_loss_cnt  <= w_loss_next;
        end
    end

    assign o_locked_ok     = r_locked_ok;
    assign o_lock_next_c   = w_lock_next;
    assign o_rst_out       = r_rst_out;
    assign o_lock_loss_cnt = r_loss_cnt;

endmodule

// File: rtl/pll_phase_ctrl.sv
// ----------------------------------------------------------------------------
// pll_phase_ctrl
// ECP5 EHXPLLL dynamic phase controller with lock supervision.
// Accepts signed phase-step requests (valid/ready) and emits PHASESEL /
// PHASEDIR / PHASESTEP sequences; filters LOCK and sequences a reset.
// Build option: define PLL_PHASE_TRACK_EN to keep per-channel phase position
// counters; otherwise phase_pos is tied to zero.
// Ports:
//   clk, reset               : reference clock, async active-high reset
//   pll_locked               : raw PLL LOCK
//   req_valid/req_ready      : request handshake
//   req_ch, req_steps        : target output, signed step count
//   phasesel/phasedir/phasestep : EHXPLLL dynamic phase port
//   busy, done, done_err     : sequencer status
//   locked_ok, rst_out       : filtered lock, downstream reset
//   lock_loss_cnt            : saturating lock-loss count
//   phase_pos                : per-channel phase position, ch0 in LSBs
// ----------------------------------------------------------------------------
module pll_phase_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned STEP_W     = 8,
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STEP_PULSE = 4,
    parameter int unsigned STEP_GAP   = 4,
    parameter int unsigned LOCK_FILT  = 1024,
    parameter int unsigned RST_HOLD   = 16,
    parameter int unsigned POS_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [CH_W-1:0]        req_ch,
    input  logic [STEP_W-1:0]      req_steps,
    output logic [CH_W-1:0]        phasesel,
    output logic                   phasedir,
    output logic                   phasestep,
    output logic                   busy,
    output logic                   done,
    output logic                   done_err,
    output logic                   locked_ok,
    output logic                   rst_out,
    output logic [LOSS_W-1:0]      lock_loss_cnt,
    output logic [N_CH*POS_W-1:0]  phase_pos
);

    localparam int unsigned TMR_W = cnt_width(max3(SETUP_CYC, STEP_PULSE, STEP_GAP));

    state_t             r_state;
    state_t             w_state_next;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_next;
    logic [STEP_W-1:0]  r_remain;
    logic [STEP_W-1:0]  w_remain_next;
    logic               r_abort;
    logic               w_abort_next;
    logic               w_err_next;
    logic               w_accept;

    logic               r_req_ready;
    logic [CH_W-1:0]    r_phasesel;
    logic               r_phasedir;
    logic               r_phasestep;
    logic               r_busy;
    logic               r_done;
    logic               r_done_err;

    logic               w_locked_ok;
    logic               w_lock_next;
    logic               w_neg;
    logic [STEP_W-1:0]  w_mag;
    logic               w_ch_bad;

    pll_lock_filter #(
        .LOCK_FILT (LOCK_FILT),
        .RST_HOLD  (RST_HOLD)
    ) u_lock_filter (
        .clk             (clk),
        .reset           (reset),
        .i_pll_locked    (pll_locked),
        .o_locked_ok     (w_locked_ok),
        .o_lock_next_c   (w_lock_next),
        .o_rst_out       (rst_out),
        .o_lock_loss_cnt (lock_loss_cnt)
    );

    // Magnitude is unsigned STEP_W bits, so the most negative request is legal
    assign w_neg    = req_steps[STEP_W-1];
    assign w_mag    = w_neg ? STEP_W'(~req_steps + STEP_W'(1)) : req_steps;
    assign w_ch_bad = (32'(req_ch) >= N_CH);

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_remain <= '0;
            r_abort  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_timer  <= w_timer_next;
            r_remain <= w_remain_next;
            r_abort  <= w_abort_next;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        w_state_next  = r_state;
        w_timer_next  = r_timer;
        w_remain_next = r_remain;
        w_abort_next  = r_abort;
        w_err_next    = 1'b0;
        w_accept      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_abort_next = 1'b0;
                if (req_valid && r_req_ready) begin
                    w_accept = 1'b1;
                    if (w_ch_bad) begin
                        w_state_next = ST_DONE;
                        w_err_next   = 1'b1;
                    end else if (w_mag == '0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next  = ST_SETUP;
                        w_timer_next  = TMR_W'(SETUP_CYC - 1);
                        w_remain_next = w_mag;
                    end
                end
            end
            ST_SETUP: begin
                if (!w_locked_ok) begin
                    w_state_next = ST_DONE;
                    w_err_next   = 1'b1;
                end else if (r_timer == '0) begin
                    w_state_next = ST_STEP_LO;
                    w_timer_next = TMR_W'(STEP_PULSE - 1);
                end else begin
                    w_timer_next = r_timer - TMR_W'(1);
                end
            end
            ST_STEP_LO: begin
                // Lock loss is remembered but the pulse always runs to length
                if (!w_locked_ok) begin
                    w_abort_next = 1'b1;
                end
                if (r_timer == '0) begin
                    w_remain_next = r_remain - STEP_W'(1);
                    if (r_abort || !w_locked_ok) begin
                        w_state_next = ST_DONE;
                        w_err_next   = 1'b1;
                    end else begin
                        w_state_next = ST_STEP_GAP;
                        w_timer_next = TMR_W'(STEP_GAP - 1);
                    end
                end else begin
                    w_timer_next = r_timer - TMR_W'(1);
                end
            end
            ST_STEP_GAP: begin
                if (!w_locked_ok) begin
                    w_state_next = ST_DONE;
                    w_err_next   = 1'b1;
                end else if (r_timer == '0) begin
                    if (r_remain != '0) begin
                        w_state_next = ST_STEP_LO;
                        w_timer_next = TMR_W'(STEP_PULSE - 1);
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end else begin
                    w_timer_next = r_timer - TMR_W'(1);
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, all derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_ready <= 1'b0;
            r_phasesel  <= '0;
            r_phasedir  <= 1'b0;
            r_phasestep <= PHASESTEP_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_done_err  <= 1'b0;
        end else begin
            r_req_ready <= (w_state_next == ST_IDLE) && w_lock_next;
            r_phasestep <= (w_state_next == ST_STEP_LO) ? ~PHASESTEP_IDLE : PHASESTEP_IDLE;
            r_busy      <= (w_state_next != ST_IDLE);
            r_done      <= (w_state_next == ST_DONE);
            r_done_err  <= w_err_next;
            // Select/direction only change for requests that will pulse
            if (w_accept && (w_state_next == ST_SETUP)) begin
                r_phasesel <= req_ch;
                r_phasedir <= w_neg;
            end else if (w_state_next == ST_IDLE) begin
                r_phasesel <= '0;
                r_phasedir <= 1'b0;
            end
        end
    end

`ifdef PLL_PHASE_TRACK_EN
    logic                   w_step_now;
    logic [N_CH*POS_W-1:0]  r_phase_pos;

    assign w_step_now = (r_state == ST_STEP_LO) && (r_timer == '0);

    // Position moves on the last low cycle of each completed pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase_pos <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_step_now && (r_phasesel == CH_W'(i))) begin
                    if (r_phasedir) begin
                        r_phase_pos[i*POS_W +: POS_W] <= r_phase_pos[i*POS_W +: POS_W] - POS_W'(1);
                    end else begin
                        r_phase_pos[i*POS_W +: POS_W] <= r_phase_pos[i*POS_W +: POS_W] + POS_W'(1);
                    end
                end
            end
        end
    end

    assign phase_pos = r_phase_pos;
`else
    assign phase_pos = '0;
`endif

    assign req_ready = r_req_ready;
    assign phasesel  = r_phasesel;
    assign phasedir  = r_phasedir;
    assign phasestep = r_phasestep;
    assign busy      = r_busy;
    assign done      = r_done;
    assign done_err  = r_done_err;
    assign locked_ok = w_locked_ok;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pll_phase_ctrl
// Directed bench for pll_phase_ctrl (N_CH=2, LOCK_FILT=16, RST_HOLD=16, other
// parameters at default: SETUP_CYC=2, STEP_PULSE=4, STEP_GAP=4).
// ----------------------------------------------------------------------------
module tb_pll_phase_ctrl;

    logic        clk;
    logic        reset;
    logic        pll_locked;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_ch;
    logic [7:0]  req_steps;
    logic [1:0]  phasesel;
    logic        phasedir;
    logic        phasestep;
    logic        busy;
    logic        done;
    logic        done_err;
    logic        locked_ok;
    logic        rst_out;
    logic [7:0]  lock_loss_cnt;
    logic [15:0] phase_pos;

    int errors = 0;
    int checks = 0;

`ifdef PLL_PHASE_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    // Per-cycle capture, index k = cycles after the accept cycle t0
    logic       cap_step [1:64];
    logic       cap_done [1:64];
    logic       cap_err  [1:64];
    logic       cap_busy [1:64];
    logic [1:0] cap_sel  [1:64];
    logic       cap_dir  [1:64];

    pll_phase_ctrl #(
        .N_CH       (2),
        .STEP_W     (8),
        .SETUP_CYC  (2),
        .STEP_PULSE (4),
        .STEP_GAP   (4),
        .LOCK_FILT  (16),
        .RST_HOLD   (16),
        .POS_W      (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_ch        (req_ch),
        .req_steps     (req_steps),
        .phasesel      (phasesel),
        .phasedir      (phasedir),
        .phasestep     (phasestep),
        .busy          (busy),
        .done          (done),
        .done_err      (done_err),
        .locked_ok     (locked_ok),
        .rst_out       (rst_out),
        .lock_loss_cnt (lock_loss_cnt),
        .phase_pos     (phase_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected PHASESTEP low: pulses start at k=3, every 8 cycles, 4 cycles long
    function automatic logic exp_low(input int k, input int n);
        return (k >= 3) && (k < 3 + 8 * n) && (((k - 3) % 8) < 4);
    endfunction

    // Present one request in the current cycle and capture ncyc cycles after it;
    // drop_k > 0 pulls pll_locked low after sampling cycle drop_k
    task automatic run_req(input logic [1:0] ch, input logic [7:0] steps,
                           input int ncyc, input int drop_k);
        req_valid = 1'b1;
        req_ch    = ch;
        req_steps = steps;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            req_valid   = 1'b0;
            cap_step[k] = phasestep;
            cap_done[k] = done;
            cap_err[k]  = done_err;
            cap_busy[k] = busy;
            cap_sel[k]  = phasesel;
            cap_dir[k]  = phasedir;
            if (k == drop_k) pll_locked = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; pll_locked = 1'b0; req_valid = 1'b0; req_ch = 2'd0; req_steps = 8'd0;
        repeat (3) @(negedge clk);
        checks++; if (phasestep !== 1'b1) begin errors++; $display("FAIL reset_phasestep got=%b exp=1", phasestep); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++; if ({busy, done, done_err, locked_ok} !== 4'b0000) begin errors++; $display("FAIL reset_status got=%b exp=0000", {busy, done, done_err, locked_ok}); end
        checks++; if (rst_out !== 1'b1) begin errors++; $display("FAIL reset_rst_out got=%b exp=1", rst_out); end
        checks++; if ({phasesel, phasedir} !== 3'b000) begin errors++; $display("FAIL reset_sel_dir got=%b exp=000", {phasesel, phasedir}); end
        checks++; if (lock_loss_cnt !== 8'd0 || phase_pos !== 16'd0) begin errors++; $display("FAIL reset_counters got=%0d/%h exp=0/0000", lock_loss_cnt, phase_pos); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lock_filter();
        pll_locked = 1'b1;
        repeat (17) @(negedge clk);
        checks++; if (locked_ok !== 1'b0) begin errors++; $display("FAIL lock_early got=%b exp=0", locked_ok); end
        @(negedge clk);
        checks++; if (locked_ok !== 1'b1) begin errors++; $display("FAIL lock_at_18 got=%b exp=1", locked_ok); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lock_req_ready got=%b exp=1", req_ready); end
        repeat (15) @(negedge clk);
        checks++; if (rst_out !== 1'b1) begin errors++; $display("FAIL rst_hold_early got=%b exp=1", rst_out); end
        @(negedge clk);
        checks++; if (rst_out !== 1'b0) begin errors++; $display("FAIL rst_release got=%b exp=0", rst_out); end
    endtask

    task automatic test_lock_glitch();
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        @(negedge clk);
        checks++; if (locked_ok !== 1'b1) begin errors++; $display("FAIL glitch_sync_delay got=%b exp=1", locked_ok); end
        @(negedge clk);
        checks++; if (locked_ok !== 1'b0 || rst_out !== 1'b1) begin errors++; $display("FAIL glitch_drop got=%b%b exp=01", locked_ok, rst_out); end
        checks++; if (lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL glitch_loss_cnt got=%0d exp=1", lock_loss_cnt); end
        repeat (15) @(negedge clk);
        checks++; if (locked_ok !== 1'b0) begin errors++; $display("FAIL refilter_early got=%b exp=0", locked_ok); end
        @(negedge clk);
        checks++; if (locked_ok !== 1'b1) begin errors++; $display("FAIL refilter_lock got=%b exp=1", locked_ok); end
        repeat (16) @(negedge clk);
        checks++; if (rst_out !== 1'b0) begin errors++; $display("FAIL refilter_rst got=%b exp=0", rst_out); end
    endtask

    task automatic test_step_pos();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL pos_ready got=%b exp=1", req_ready); end
        run_req(2'd1, 8'd3, 29, 0);
        for (int k = 1; k <= 29; k++) begin
            checks++; if (cap_step[k] !== !exp_low(k, 3)) begin errors++; $display("FAIL pos_phasestep k=%0d got=%b exp=%b", k, cap_step[k], !exp_low(k, 3)); end
            checks++; if (cap_done[k] !== (k == 27)) begin errors++; $display("FAIL pos_done k=%0d got=%b exp=%b", k, cap_done[k], (k == 27)); end
            checks++; if (cap_busy[k] !== (k <= 27)) begin errors++; $display("FAIL pos_busy k=%0d got=%b exp=%b", k, cap_busy[k], (k <= 27)); end
            checks++; if (cap_err[k] !== 1'b0) begin errors++; $display("FAIL pos_done_err k=%0d got=%b exp=0", k, cap_err[k]); end
            if (k <= 27) begin
                checks++; if (cap_sel[k] !== 2'd1 || cap_dir[k] !== 1'b0) begin errors++; $display("FAIL pos_sel_dir k=%0d got=%0d/%b exp=1/0", k, cap_sel[k], cap_dir[k]); end
            end
        end
        checks++; if (phase_pos !== {(TRACK ? 8'd3 : 8'd0), 8'd0}) begin errors++; $display("FAIL pos_phase_pos got=%h exp=%h", phase_pos, {(TRACK ? 8'd3 : 8'd0), 8'd0}); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL pos_ready_after got=%b exp=1", req_ready); end
    endtask

    task automatic test_step_neg();
        run_req(2'd0, 8'd1, 12, 0);
        checks++; if (cap_done[11] !== 1'b1 || cap_done[10] !== 1'b0) begin errors++; $display("FAIL neg_pre_done got=%b%b exp=01", cap_done[10], cap_done[11]); end
        checks++; if (phase_pos[7:0] !== (TRACK ? 8'd1 : 8'd0)) begin errors++; $display("FAIL neg_pre_pos got=%0d exp=%0d", phase_pos[7:0], (TRACK ? 1 : 0)); end
        run_req(2'd0, 8'hFE, 21, 0);
        for (int k = 1; k <= 21; k++) begin
            checks++; if (cap_step[k] !== !exp_low(k, 2)) begin errors++; $display("FAIL neg_phasestep k=%0d got=%b exp=%b", k, cap_step[k], !exp_low(k, 2)); end
            checks++; if (cap_done[k] !== (k == 19)) begin errors++; $display("FAIL neg_done k=%0d got=%b exp=%b", k, cap_done[k], (k == 19)); end
            if (k <= 19) begin
                checks++; if (cap_sel[k] !== 2'd0 || cap_dir[k] !== 1'b1) begin errors++; $display("FAIL neg_sel_dir k=%0d got=%0d/%b exp=0/1", k, cap_sel[k], cap_dir[k]); end
            end
        end
        checks++; if (cap_err[19] !== 1'b0) begin errors++; $display("FAIL neg_done_err got=%b exp=0", cap_err[19]); end
        checks++; if (phase_pos !== (TRACK ? 16'h03FF : 16'h0000)) begin errors++; $display("FAIL neg_wrap got=%h exp=%h", phase_pos, (TRACK ? 16'h03FF : 16'h0000)); end
    endtask

    task automatic test_zero_and_bad_ch();
        run_req(2'd1, 8'd0, 3, 0);
        checks++; if ({cap_done[1], cap_err[1], cap_done[2]} !== 3'b100) begin errors++; $display("FAIL zero_done got=%b exp=100", {cap_done[1], cap_err[1], cap_done[2]}); end
        checks++; if ({cap_step[1], cap_step[2], cap_step[3]} !== 3'b111) begin errors++; $display("FAIL zero_no_pulse got=%b exp=111", {cap_step[1], cap_step[2], cap_step[3]}); end
        checks++; if ({cap_busy[1], cap_busy[2]} !== 2'b10) begin errors++; $display("FAIL zero_busy got=%b exp=10", {cap_busy[1], cap_busy[2]}); end
        run_req(2'd3, 8'd5, 3, 0);
        checks++; if ({cap_done[1], cap_err[1], cap_done[2]} !== 3'b110) begin errors++; $display("FAIL badch3_done got=%b exp=110", {cap_done[1], cap_err[1], cap_done[2]}); end
        checks++; if ({cap_step[1], cap_step[2], cap_step[3]} !== 3'b111) begin errors++; $display("FAIL badch3_no_pulse got=%b exp=111", {cap_step[1], cap_step[2], cap_step[3]}); end
        run_req(2'd2, 8'd1, 3, 0);
        checks++; if ({cap_done[1], cap_err[1]} !== 2'b11) begin errors++; $display("FAIL badch2_done got=%b exp=11", {cap_done[1], cap_err[1]}); end
        checks++; if (phase_pos !== (TRACK ? 16'h03FF : 16'h0000)) begin errors++; $display("FAIL badch_pos got=%h exp=%h", phase_pos, (TRACK ? 16'h03FF : 16'h0000)); end
    endtask

    task automatic test_lock_abort();
        // LOCK drops in the first low cycle of pulse 2 (k=11); locked_ok falls
        // at k=14, the pulse still ends at k=14 and DONE follows at k=15
        run_req(2'd1, 8'd5, 20, 11);
        for (int k = 1; k <= 20; k++) begin
            checks++; if (cap_step[k] !== !exp_low(k, 2)) begin errors++; $display("FAIL abort_phasestep k=%0d got=%b exp=%b", k, cap_step[k], !exp_low(k, 2)); end
            checks++; if (cap_done[k] !== (k == 15)) begin errors++; $display("FAIL abort_done k=%0d got=%b exp=%b", k, cap_done[k], (k == 15)); end
        end
        checks++; if (cap_err[15] !== 1'b1) begin errors++; $display("FAIL abort_done_err got=%b exp=1", cap_err[15]); end
        // Second loss overall: the earlier glitch produced the first
        checks++; if (lock_loss_cnt !== 8'd2 || rst_out !== 1'b1) begin errors++; $display("FAIL abort_loss got=%0d/%b exp=2/1", lock_loss_cnt, rst_out); end
        checks++; if (phase_pos !== (TRACK ? 16'h05FF : 16'h0000)) begin errors++; $display("FAIL abort_pos got=%h exp=%h", phase_pos, (TRACK ? 16'h05FF : 16'h0000)); end
        repeat (10) @(negedge clk);
        checks++; if (req_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_ready_low got=%b%b exp=00", req_ready, busy); end
        pll_locked = 1'b1;
        repeat (17) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL relock_early got=%b exp=0", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || locked_ok !== 1'b1) begin errors++; $display("FAIL relock_ready got=%b%b exp=11", req_ready, locked_ok); end
    endtask

    task automatic test_reset_mid_op();
        req_valid = 1'b1; req_ch = 2'd0; req_steps = 8'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (phasestep !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_in_pulse got=%b%b exp=01", phasestep, busy); end
        reset = 1'b1;
        #1;
        checks++; if (phasestep !== 1'b1) begin errors++; $display("FAIL mid_rst_phasestep got=%b exp=1", phasestep); end
        checks++; if ({busy, done, req_ready, locked_ok} !== 4'b0000) begin errors++; $display("FAIL mid_rst_status got=%b exp=0000", {busy, done, req_ready, locked_ok}); end
        checks++; if (rst_out !== 1'b1) begin errors++; $display("FAIL mid_rst_rst_out got=%b exp=1", rst_out); end
        checks++; if (lock_loss_cnt !== 8'd0 || phase_pos !== 16'd0) begin errors++; $display("FAIL mid_rst_counters got=%0d/%h exp=0/0000", lock_loss_cnt, phase_pos); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lock_filter();
        test_lock_glitch();
        test_step_pos();
        test_step_neg();
        test_zero_and_bad_ch();
        test_lock_abort();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
